// File: rtl/vga_entity_map.sv
// Cell-based entity map feeding the VGA colour stage: 2-bit code per cell,
// game-side req/ack writes, fixed-latency pixel reads and a full-map clear sweep.
module vga_entity_map #(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int CELL_SHIFT = 4,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic       VGA_clk,
    input  logic       rst,
    input  logic [9:0] VGA_X,
    input  logic [9:0] VGA_Y,
    input  logic       wr_req,
    input  logic [5:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [1:0] wr_ent,
    input  logic       clr_req,
    output logic       wr_ack,
    output logic       wr_err,
    output logic       busy,
    output logic [0:1] ent
);

    localparam int          CELLS     = GRID_W * GRID_H;
    localparam logic [10:0] LAST_ADDR = 11'(CELLS - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t      state_q, state_d;
    logic [10:0] clr_addr_q, clr_addr_d;

    logic [1:0]  mem [CELLS];
    logic        mem_we;
    logic [10:0] mem_wa;
    logic [1:0]  mem_wd;

    logic [9:0]  pix_col, pix_row;
    logic        pix_act;
    logic [10:0] pix_addr, wr_addr;
    logic        wr_in_range, wr_accept;

    logic [10:0] addr_p0;
    logic        act_p0, busy_p0;
    logic [1:0]  mem_q_p1;
    logic        act_p1, busy_p1;

    // row*GRID_W + col; the default 40-wide grid uses 32+8 shifts instead of a multiplier
    function automatic logic [10:0] cell_addr(input logic [9:0] row, input logic [9:0] col);
        if (GRID_W == 40)
            return (11'(row) << 5) + (11'(row) << 3) + 11'(col);
        else
            return 11'(row) * 11'(GRID_W) + 11'(col);
    endfunction

    assign pix_col     = VGA_X >> CELL_SHIFT;
    assign pix_row     = VGA_Y >> CELL_SHIFT;
    assign pix_act     = (VGA_X < 10'(H_ACTIVE)) && (VGA_Y < 10'(V_ACTIVE));
    assign pix_addr    = cell_addr(pix_row, pix_col);
    assign wr_addr     = cell_addr({5'd0, wr_row}, {4'd0, wr_col});
    assign wr_in_range = ({4'd0, wr_col} < 10'(GRID_W)) && ({5'd0, wr_row} < 10'(GRID_H));
    // A clear request in the same cycle wins; the write simply stays pending
    assign wr_accept   = (state_q == IDLE) && !clr_req && wr_req && !wr_ack;
    assign busy        = (state_q == CLEAR);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 11'd1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_addr_q;
        mem_wd = 2'b11;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
        end else if (wr_accept && wr_in_range) begin
            mem_we = 1'b1;
            mem_wa = wr_addr;
            mem_wd = wr_ent;
        end
    end

    always_ff @(posedge VGA_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            act_p0     <= 1'b0;
            busy_p0    <= 1'b1;
            act_p1     <= 1'b0;
            busy_p1    <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            wr_ack     <= wr_accept;
            wr_err     <= wr_accept && !wr_in_range;
            // stage 0: pixel flags
            act_p0     <= pix_act;
            busy_p0    <= busy;
            // stage 1: flags aligned with the memory read
            act_p1     <= act_p0;
            busy_p1    <= busy_p0;
        end
    end

    always_ff @(posedge VGA_clk) begin
        // stage 0: cell address (blanking pixels park on cell 0)
        addr_p0 <= pix_act ? pix_addr : '0;
        if (mem_we)
            mem[mem_wa] <= mem_wd;
        // stage 1: read sees the pre-write contents on a same-address collision
        mem_q_p1 <= mem[addr_p0];
    end

    // stage 2: blanking and in-progress clears show as empty
    always_comb begin
        ent = 2'b11;
        if (act_p1 && !busy_p1)
            ent = mem_q_p1;
    end

endmodule

// File: tb/tb_vga_entity_map.sv
// Scoreboard bench for vga_entity_map: random/directed pixels and writes checked
// against a cell-array reference model of the map.
module tb_vga_entity_map;

    logic       VGA_clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] VGA_X = 10'd700;
    logic [9:0] VGA_Y = 10'd500;
    logic       wr_req = 1'b0;
    logic [5:0] wr_col = '0;
    logic [4:0] wr_row = '0;
    logic [1:0] wr_ent = '0;
    logic       clr_req = 1'b0;
    logic       wr_ack, wr_err, busy;
    logic [0:1] ent;

    always #5 VGA_clk = ~VGA_clk;

    vga_entity_map dut (
        .VGA_clk (VGA_clk),
        .rst     (rst),
        .VGA_X   (VGA_X),
        .VGA_Y   (VGA_Y),
        .wr_req  (wr_req),
        .wr_col  (wr_col),
        .wr_row  (wr_row),
        .wr_ent  (wr_ent),
        .clr_req (clr_req),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .busy    (busy),
        .ent     (ent)
    );

    typedef struct { int x; int y; } pix_t;
    typedef struct { int due; logic [1:0] exp; int x; int y; } sb_t;

    logic [1:0] model_mem [1200];
    bit   in_clear = 1'b1;
    bit   rand_en  = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    pix_t pix_q[$];
    sb_t  sb_q[$];

    function automatic logic [1:0] ref_ent(input int x, input int y);
        if (in_clear || x >= 640 || y >= 480)
            return 2'b11;
        return model_mem[(y / 16) * 40 + (x / 16)];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Pixel driver: every falling edge presents one pixel and records its expected code
    always @(negedge VGA_clk) begin
        pix_t p;
        if (pix_q.size() > 0) begin
            p = pix_q.pop_front();
        end else if (rand_en) begin
            p.x = int'($urandom_range(799, 0));
            p.y = int'($urandom_range(524, 0));
        end else begin
            p.x = 700;
            p.y = 500;
        end
        VGA_X = 10'(p.x);
        VGA_Y = 10'(p.y);
        sb_q.push_back('{cyc + 2, ref_ent(p.x, p.y), p.x, p.y});
    end

    // Monitor: ent is valid every cycle, two rising edges after the pixel was presented
    always begin
        @(posedge VGA_clk);
        cyc++;
        #2;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            sb_t e;
            e = sb_q.pop_front();
            n_vec++;
            if (ent !== e.exp) begin
                n_err++;
                $display("FAIL ent pixel(%0d,%0d): got %b want %b", e.x, e.y, ent, e.exp);
            end
        end
    end

    task automatic model_all_empty();
        for (int i = 0; i < 1200; i++) model_mem[i] = 2'b11;
    endtask

    task automatic wait_clear(input int exp_n, input int pulse_at);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 5000) begin
            @(posedge VGA_clk);
            n++;
            #1;
            clr_req = (n == pulse_at);
            if (busy) chk("no_ack_in_clear", {31'd0, wr_ack}, 32'd0);
            else done = 1'b1;
        end
        clr_req = 1'b0;
        chk("clear_len", n, exp_n);
        model_all_empty();
        in_clear = 1'b0;
    endtask

    task automatic wait_ack(input int col, input int row, input logic [1:0] e, input bit exp_err);
        int k;
        k = 0;
        do begin
            @(negedge VGA_clk);
            #1;
            k++;
        end while (!wr_ack && k < 40);
        chk("wr_ack", {31'd0, wr_ack}, 32'd1);
        chk("wr_err", {31'd0, wr_err}, {31'd0, exp_err});
        wr_req = 1'b0;
        if (wr_ack && !exp_err) model_mem[row * 40 + col] = e;
        @(negedge VGA_clk);
        #1;
        chk("ack_pulse", {31'd0, wr_ack}, 32'd0);
    endtask

    task automatic do_write(input int col, input int row, input logic [1:0] e);
        bit exp_err;
        exp_err = (col >= 40) || (row >= 30);
        @(negedge VGA_clk);
        #1;
        wr_col = 6'(col);
        wr_row = 5'(row);
        wr_ent = e;
        wr_req = 1'b1;
        wait_ack(col, row, e, exp_err);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (pix_q.size() > 0 && k < 5000) begin
            @(negedge VGA_clk);
            k++;
        end
        repeat (4) @(negedge VGA_clk);
        #1;
    endtask

    task automatic push_pix(input int x, input int y);
        pix_q.push_back('{x, y});
    endtask

    task automatic readback_all();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 40; c++)
                push_pix(c * 16 + 8, r * 16 + 8);
        drain();
    endtask

    task automatic scan_rand(input int n);
        for (int i = 0; i < n; i++)
            push_pix(int'($urandom_range(799, 0)), int'($urandom_range(524, 0)));
        drain();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        model_all_empty();
        #1 rst = 1'b0;
        repeat (3) @(negedge VGA_clk);
        #1;
        chk("rst_ent", {30'd0, ent}, 32'h3);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_ack", {31'd0, wr_ack}, 32'd0);
        chk("rst_err", {31'd0, wr_err}, 32'd0);

        // Initial sweep, with a clear request mid-sweep that must be ignored
        @(negedge VGA_clk);
        #1 rst = 1'b1;
        wait_clear(1200, 300);
        scan_rand(200);
        rand_en = 1'b0;

        // Head cell at (3,2) and its pixel block edges
        do_write(3, 2, 2'b01);
        for (int y = 31; y <= 48; y++)
            for (int x = 47; x <= 64; x++)
                push_pix(x, y);
        drain();

        // Bottom-right corner cell and the first blanking column
        do_write(39, 29, 2'b00);
        push_pix(639, 479);
        push_pix(640, 479);
        push_pix(639, 480);
        push_pix(624, 464);
        push_pix(623, 479);
        drain();

        // Out-of-range writes leave the map untouched
        do_write(40, 0, 2'b10);
        do_write(0, 30, 2'b00);
        do_write(63, 31, 2'b01);
        readback_all();

        // Random write mix including out-of-range targets
        for (int i = 0; i < 24; i++)
            do_write(int'($urandom_range(41, 0)), int'($urandom_range(31, 0)),
                     2'($urandom_range(3, 0)));
        scan_rand(400);
        readback_all();

        // Clear and write in the same cycle: clear first, write accepted afterwards
        @(negedge VGA_clk);
        #1;
        clr_req = 1'b1;
        wr_req  = 1'b1;
        wr_col  = 6'd0;
        wr_row  = 5'd0;
        wr_ent  = 2'b10;
        in_clear = 1'b1;
        wait_clear(1201, 0);
        wait_ack(0, 0, 2'b10, 1'b0);
        push_pix(0, 0);
        push_pix(15, 15);
        push_pix(16, 0);
        push_pix(0, 16);
        drain();
        readback_all();

        // Reset while an ack is outstanding discards it
        @(negedge VGA_clk);
        #1;
        wr_col = 6'd5;
        wr_row = 5'd5;
        wr_ent = 2'b01;
        wr_req = 1'b1;
        @(posedge VGA_clk);
        #1;
        chk("ack_before_rst", {31'd0, wr_ack}, 32'd1);
        rst = 1'b0;
        in_clear = 1'b1;
        #1;
        chk("ack_discard", {31'd0, wr_ack}, 32'd0);
        chk("rst_busy2", {31'd0, busy}, 32'd1);
        wr_req = 1'b0;
        repeat (2) @(negedge VGA_clk);
        #1 rst = 1'b1;
        wait_clear(1200, 0);
        readback_all();

        // Reset at clr_addr=600 restarts the sweep from zero
        do_write(7, 7, 2'b10);
        @(negedge VGA_clk);
        #1;
        clr_req = 1'b1;
        in_clear = 1'b1;
        rand_en = 1'b1;
        @(posedge VGA_clk);
        #1 clr_req = 1'b0;
        repeat (600) @(posedge VGA_clk);
        #1 rst = 1'b0;
        #1;
        chk("midclr_rst_ent", {30'd0, ent}, 32'h3);
        chk("midclr_rst_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge VGA_clk);
        #1 rst = 1'b1;
        wait_clear(1200, 0);
        scan_rand(300);
        rand_en = 1'b0;
        readback_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_entity_map.md
Name: vga_entity_map

Overview:
- Cell-based entity store sitting directly upstream of the VGA colour stage. It supplies the 2-bit entity code for the pixel currently being scanned.
- Holds a GRID_W x GRID_H map of 2-bit cells, each cell 2^CELL_SHIFT pixels square.
- Game logic updates cells through a req/ack write port.
- The VGA side reads cells continuously, with fixed pipeline latency.
- An internal clear sequencer fills the map with "empty" after reset or on request.

Parameters:
- GRID_W, 40, cells per row (640 px / 16)
- GRID_H, 30, cells per column (480 px / 16)
- CELL_SHIFT, 4, log2 of cell size in pixels
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame

Ports:
- VGA_clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- VGA_X  in  10  current pixel column
- VGA_Y  in  10  current pixel row
- wr_req  in  1  write request; held high until wr_ack
- wr_col  in  6  target cell column
- wr_row  in  5  target cell row
- wr_ent  in  2  code to store: 11 empty, 01 head, 10 body, 00 food
- clr_req  in  1  one-cycle pulse; starts a full-map clear
- wr_ack  out  1  one-cycle pulse; write request consumed
- wr_err  out  1  one-cycle pulse, coincident with wr_ack, when col/row is out of range
- busy  out  1  high while a clear is in progress
- ent  out  2 ([0:1])  entity code for the pixel presented two cycles earlier

Behaviour:
- Reset (rst=0): ent=2'b11, wr_ack=0, wr_err=0, busy=1, FSM=CLEAR, clr_addr=0. Applies asynchronously.
- Releasing rst starts the clear sweep on the first VGA_clk edge.
- Storage: dual-port memory, GRID_W*GRID_H entries x 2 bits.
  - Synchronous read port serves the pixel path.
  - Synchronous write port is shared by the clear sequencer and the game write port.
- Address arithmetic: addr = row*GRID_W + col, 11 bits.
  - For the default GRID_W=40, compute it as (row<<5)+(row<<3)+col. No multiplier or divider.
  - Pixel path: col = VGA_X >> CELL_SHIFT, row = VGA_Y >> CELL_SHIFT.
- Pixel pipeline, latency 2:
  - Cycle 0: register addr and the in_active flag (VGA_X<H_ACTIVE and VGA_Y<V_ACTIVE).
  - Cycle 1: memory read.
  - Cycle 2: ent = (in_active_d && !busy_d) ? mem_q : 2'b11.
  - The pipeline runs every cycle, with no stalls.
- Read/write collision on the same address in the same cycle: read returns the old value.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle, write 2'b11 at clr_addr, then clr_addr++.
  - When clr_addr = GRID_W*GRID_H-1 is written, go to IDLE next cycle and drop busy. A full clear takes 1200 cycles.
  - clr_req during CLEAR is ignored; the sweep does not restart.
  - IDLE with clr_req=1: go to CLEAR, clr_addr=0, busy=1 next cycle.
- Write port:
  - Accepted only in IDLE, and only when clr_req=0 in that cycle.
  - On acceptance: the memory write happens that cycle, and wr_ack pulses high on the following cycle.
  - While wr_ack is high, a new request is not accepted. The master must drop wr_req after seeing wr_ack; if wr_req stays high, the earliest re-accept is the cycle after the ack.
  - Maximum throughput is one write per 2 cycles.
  - wr_col>=GRID_W or wr_row>=GRID_H: no memory write; wr_ack and wr_err pulse together.
- Simultaneous events:
  - clr_req and wr_req in the same IDLE cycle: the clear wins and the write stays pending.
  - A pending write is accepted after the clear completes. No ack is issued during CLEAR.
- Reset mid-clear: the sweep restarts from address 0 after release.
- Reset mid-write: any ack pending in the pipeline is discarded.
- Out-of-visible-area pixels (blanking) always produce ent=2'b11.

Test Plan:
- Release rst, count cycles until busy=0 -> exactly 1200 cycles; ent=2'b11 for every pixel throughout and afterwards.
- After the clear, write col=3,row=2,ent=01, then present VGA_X=48..63, VGA_Y=32..47 -> ent=2'b01 two cycles after each such pixel. VGA_X=64 -> 2'b11.
- Write col=39,row=29,ent=00, then present pixel (639,479) -> ent=00. Pixel (640,479) -> 11.
- wr_req with col=40,row=0 -> wr_ack=1 and wr_err=1 on the same cycle; full map readback shows all cells still 11.
- Assert clr_req and wr_req (col=0,row=0,ent=10) in the same cycle -> busy=1; no wr_ack for 1200 cycles; then wr_ack and cell (0,0)=10.
- Pull rst low at clr_addr=600 mid-clear, then release -> busy stays high for a fresh 1200 cycles; ent=2'b11 immediately on reset assertion.
